// File: rtl/dunit_pkg.sv
// rtl/dunit_pkg.sv - command/ack byte codes and FSM encoding shared by the debug unit
package dunit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h52;

  localparam logic [7:0] ACK_OK   = 8'h4B;
  localparam logic [7:0] ACK_HALT = 8'h48;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_LOAD_WR,
    ST_RUN,
    ST_STEP,
    ST_DUMP_SEL,
    ST_DUMP_LATCH,
    ST_DUMP_TX,
    ST_DUMP_WAIT,
    ST_ACK_TX,
    ST_ACK_WAIT
  } state_t;

endpackage

// File: rtl/dunit_word_shifter.sv
// rtl/dunit_word_shifter.sv - byte<->word shifter with byte counter, MSB first in both directions
module dunit_word_shifter #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_byte_in_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  input  logic               i_word_load,
  input  logic [NB_REG-1:0]  i_word,
  input  logic               i_byte_out_next,
  output logic [NB_REG-1:0]  o_word,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_last
);

  localparam int N_BYTES = NB_REG / NB_BYTE;
  localparam int NB_CNT  = $clog2(N_BYTES);

  logic [NB_REG-1:0] r_word;
  logic [NB_CNT-1:0] r_cnt;

  // Both directions shift toward the MSB, so o_byte is always the next byte to send.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_word_load) begin
      r_word <= i_word;
      r_cnt  <= '0;
    end else if (i_byte_in_valid) begin
      r_word <= {r_word[NB_REG-NB_BYTE-1:0], i_byte};
      r_cnt  <= r_cnt + 1'b1;
    end else if (i_byte_out_next) begin
      r_word <= {r_word[NB_REG-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_word = r_word;
  assign o_byte = r_word[NB_REG-1 -: NB_BYTE];
  assign o_last = (r_cnt == NB_CNT'(N_BYTES - 1));

endmodule

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-driven host control: program load, run/step, register and memory dump
module debug_unit
  import dunit_pkg::*;
#(
  parameter int NB_REG      = 32,
  parameter int NB_WIDHT    = 9,
  parameter int NB_ADDR     = 5,
  parameter int NB_BYTE     = 8,
  parameter int N_MEM_WORDS = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_done,
  input  logic                i_tx_done,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_start,
  input  logic                i_halt,
  input  logic [NB_REG-1:0]   i_dunit_reg,
  input  logic [NB_REG-1:0]   i_dunit_mem_data,
  output logic                o_dunit_clk_en,
  output logic                o_dunit_reset_pc,
  output logic                o_dunit_w_mem,
  output logic [NB_WIDHT-1:0] o_dunit_addr,
  output logic [NB_REG-1:0]   o_dunit_data_if
);

  localparam int N_REGS  = 2 ** NB_ADDR;
  localparam int N_WORDS = N_REGS + N_MEM_WORDS;
  localparam int NB_IDX  = $clog2(N_WORDS);
  localparam logic [NB_IDX-1:0] IDX_FIRST_MEM = NB_IDX'(N_REGS);
  localparam logic [NB_IDX-1:0] IDX_LAST      = NB_IDX'(N_WORDS - 1);

  state_t r_state;
  state_t w_next_state;

  logic [NB_BYTE-1:0] r_n;
  logic [NB_BYTE-1:0] r_k;
  logic [NB_IDX-1:0]  r_idx;
  logic [NB_BYTE-1:0] r_ack;

  logic               w_n_load;
  logic               w_k_clr;
  logic               w_k_inc;
  logic               w_idx_clr;
  logic               w_idx_inc;
  logic               w_ack_load;
  logic [NB_BYTE-1:0] w_ack_val;

  logic               w_sh_clear;
  logic               w_sh_in;
  logic               w_sh_load;
  logic               w_sh_next;
  logic [NB_REG-1:0]  w_sh_word_in;
  logic [NB_REG-1:0]  w_sh_word;
  logic [NB_BYTE-1:0] w_sh_byte;
  logic               w_sh_last;

  logic                w_is_reg_phase;
  logic [NB_IDX-1:0]   w_mem_j;
  logic [NB_WIDHT-1:0] w_dump_addr;
  logic [NB_WIDHT-1:0] w_load_addr;

  // Dump index walks registers first, then data words; byte addresses wrap to NB_WIDHT bits.
  assign w_is_reg_phase = (r_idx < IDX_FIRST_MEM);
  assign w_mem_j        = r_idx - IDX_FIRST_MEM;
  assign w_dump_addr    = w_is_reg_phase ? NB_WIDHT'(r_idx[NB_ADDR-1:0])
                                         : NB_WIDHT'({w_mem_j, 2'b00});
  assign w_load_addr    = NB_WIDHT'({r_k, 2'b00});
  assign w_sh_word_in   = w_is_reg_phase ? i_dunit_reg : i_dunit_mem_data;

  dunit_word_shifter #(
    .NB_REG  (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_shifter (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_clear         (w_sh_clear),
    .i_byte_in_valid (w_sh_in),
    .i_byte          (i_rx_data),
    .i_word_load     (w_sh_load),
    .i_word          (w_sh_word_in),
    .i_byte_out_next (w_sh_next),
    .o_word          (w_sh_word),
    .o_byte          (w_sh_byte),
    .o_last          (w_sh_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_n_load         = 1'b0;
    w_k_clr          = 1'b0;
    w_k_inc          = 1'b0;
    w_idx_clr        = 1'b0;
    w_idx_inc        = 1'b0;
    w_ack_load       = 1'b0;
    w_ack_val        = ACK_OK;
    w_sh_clear       = 1'b0;
    w_sh_in          = 1'b0;
    w_sh_load        = 1'b0;
    w_sh_next        = 1'b0;
    o_tx_start       = 1'b0;
    o_tx_data        = '0;
    o_dunit_clk_en   = 1'b0;
    o_dunit_reset_pc = 1'b0;
    o_dunit_w_mem    = 1'b0;
    o_dunit_addr     = '0;
    o_dunit_data_if  = '0;

    case (r_state)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: w_next_state = ST_LOAD_CNT;
            CMD_RUN:  w_next_state = ST_RUN;
            CMD_STEP: w_next_state = ST_STEP;
            CMD_DUMP: begin
              w_next_state = ST_DUMP_SEL;
              w_idx_clr    = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_LOAD_CNT: begin
        o_dunit_reset_pc = 1'b1;
        if (i_rx_done) begin
          w_n_load   = 1'b1;
          w_k_clr    = 1'b1;
          w_sh_clear = 1'b1;
          if (i_rx_data == '0) begin
            w_ack_load   = 1'b1;
            w_ack_val    = ACK_OK;
            w_next_state = ST_ACK_TX;
          end else begin
            w_next_state = ST_LOAD_BYTE;
          end
        end
      end

      ST_LOAD_BYTE: begin
        o_dunit_reset_pc = 1'b1;
        if (i_rx_done) begin
          w_sh_in = 1'b1;
          if (w_sh_last) begin
            w_next_state = ST_LOAD_WR;
          end
        end
      end

      ST_LOAD_WR: begin
        o_dunit_reset_pc = 1'b1;
        o_dunit_w_mem    = 1'b1;
        o_dunit_addr     = w_load_addr;
        o_dunit_data_if  = w_sh_word;
        w_k_inc          = 1'b1;
        if ((r_k + 1'b1) == r_n) begin
          w_ack_load   = 1'b1;
          w_ack_val    = ACK_OK;
          w_next_state = ST_ACK_TX;
        end else begin
          w_next_state = ST_LOAD_BYTE;
        end
      end

      // Enable is gated by i_halt combinationally so it drops in the halt cycle itself.
      ST_RUN: begin
        o_dunit_clk_en = !i_halt;
        if (i_halt) begin
          w_ack_load   = 1'b1;
          w_ack_val    = ACK_HALT;
          w_next_state = ST_ACK_TX;
        end
      end

      ST_STEP: begin
        o_dunit_clk_en = !i_halt;
        w_ack_load     = 1'b1;
        w_ack_val      = ACK_OK;
        w_next_state   = ST_ACK_TX;
      end

      ST_DUMP_SEL: begin
        o_dunit_addr = w_dump_addr;
        w_next_state = ST_DUMP_LATCH;
      end

      ST_DUMP_LATCH: begin
        o_dunit_addr = w_dump_addr;
        w_sh_load    = 1'b1;
        w_next_state = ST_DUMP_TX;
      end

      ST_DUMP_TX: begin
        o_tx_start   = 1'b1;
        o_tx_data    = w_sh_byte;
        w_next_state = ST_DUMP_WAIT;
      end

      ST_DUMP_WAIT: begin
        o_tx_data = w_sh_byte;
        if (i_tx_done) begin
          if (!w_sh_last) begin
            w_sh_next    = 1'b1;
            w_next_state = ST_DUMP_TX;
          end else if (r_idx == IDX_LAST) begin
            w_next_state = ST_IDLE;
          end else begin
            w_idx_inc    = 1'b1;
            w_next_state = ST_DUMP_SEL;
          end
        end
      end

      ST_ACK_TX: begin
        o_tx_start   = 1'b1;
        o_tx_data    = r_ack;
        w_next_state = ST_ACK_WAIT;
      end

      ST_ACK_WAIT: begin
        o_tx_data = r_ack;
        if (i_tx_done) begin
          w_next_state = ST_IDLE;
        end
      end

      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_n   <= '0;
      r_k   <= '0;
      r_idx <= '0;
      r_ack <= '0;
    end else begin
      if (w_n_load) begin
        r_n <= i_rx_data;
      end
      if (w_k_clr) begin
        r_k <= '0;
      end else if (w_k_inc) begin
        r_k <= r_k + 1'b1;
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_ack_load) begin
        r_ack <= w_ack_val;
      end
    end
  end

endmodule
